// File: rtl/freq_bcd_conv_if.sv
// Bus between the frequency meter (master) and the BCD converter (slave).
// It carries the measured word and its update strobe in, and the display result out.
interface freq_bcd_conv_if #(
    parameter int W = 32,
    parameter int D = 10
);
    logic [W-1:0]   freq_in;
    logic           ovf_in;
    logic           upd;
    logic [4*D-1:0] bcd;
    logic [D-1:0]   blank;
    logic [3:0]     ndig;
    logic           ovf;
    logic           valid;
    logic           busy;
    logic           ovr;

    modport master (
        output freq_in, ovf_in, upd,
        input  bcd, blank, ndig, ovf, valid, busy, ovr
    );

    modport slave (
        input  freq_in, ovf_in, upd,
        output bcd, blank, ndig, ovf, valid, busy, ovr
    );
endinterface

// File: rtl/freq_bcd_conv.sv
// Binary-to-BCD converter for a frequency display, using shift-and-add-3.
// It also produces a leading-zero mask and a significant-digit count.
module freq_bcd_conv #(
    parameter int W = 32,
    parameter int D = 10
) (
    input logic            clk,
    input logic            reset,
    freq_bcd_conv_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic           sync1, sync2, sync3, primed, armed, req;
    logic [W-1:0]   hold_freq, hold_freq_nx;
    logic           hold_ovf, hold_ovf_nx;
    logic [1:0]     state;
    logic [W-1:0]   bin;
    logic [4*D-1:0] scratch, scratch_adj, scratch_nx;
    logic [5:0]     cnt;
    logic           pending, conv_ovf, start, last;
    logic [3:0]     ndig_c;
    logic [D-1:0]   blank_c;
    logic [4*D-1:0] bcd_r;
    logic [D-1:0]   blank_r;
    logic [3:0]     ndig_r;
    logic           ovf_r, ovr_r;

    // armed stays low until sync1 has seen upd low, so a level that is already high at release is ignored
    assign req = sync2 & ~sync3 & armed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            primed <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync1  <= bus.upd;
            sync2  <= sync1;
            sync3  <= sync2;
            primed <= 1'b1;
            armed  <= armed | (primed & ~sync1);
        end
    end

    assign hold_freq_nx = req ? bus.freq_in : hold_freq;
    assign hold_ovf_nx  = req ? bus.ovf_in  : hold_ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_freq <= '0;
            hold_ovf  <= 1'b0;
        end else begin
            hold_freq <= hold_freq_nx;
            hold_ovf  <= hold_ovf_nx;
        end
    end

    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < D; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        scratch_nx = {scratch_adj[4*D-2:0], bin[W-1]};
        ndig_c = 4'd1;
        for (int i = 1; i < D; i++) begin
            if (scratch_nx[4*i +: 4] != 4'd0)
                ndig_c = 4'(i + 1);
        end
        blank_c = '0;
        for (int i = 0; i < D; i++)
            blank_c[i] = (i >= int'(ndig_c));
    end

    assign last  = (cnt == 6'(W - 1));
    assign start = ((state == IDLE) && req) || ((state == DONE) && (pending || req));

    // Results are loaded on the final shift so they are already valid in the DONE cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bin      <= '0;
            scratch  <= '0;
            cnt      <= '0;
            conv_ovf <= 1'b0;
            bcd_r    <= '0;
            blank_r  <= {{(D-1){1'b1}}, 1'b0};
            ndig_r   <= 4'd1;
            ovf_r    <= 1'b0;
        end else if (start) begin
            state    <= SHIFT;
            bin      <= hold_freq_nx;
            conv_ovf <= hold_ovf_nx;
            scratch  <= '0;
            cnt      <= '0;
        end else if (state == SHIFT) begin
            scratch <= scratch_nx;
            bin     <= {bin[W-2:0], 1'b0};
            cnt     <= cnt + 6'd1;
            if (last) begin
                state   <= DONE;
                bcd_r   <= scratch_nx;
                blank_r <= blank_c;
                ndig_r  <= ndig_c;
                ovf_r   <= conv_ovf;
            end
        end else begin
            state <= IDLE;
        end
    end

    // A request arriving in DONE is consumed immediately by start, so pending only accumulates in SHIFT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            if (state == SHIFT)
                pending <= pending | req;
            else
                pending <= 1'b0;
            if (req && pending && (state != IDLE))
                ovr_r <= 1'b1;
        end
    end

    assign bus.bcd   = bcd_r;
    assign bus.blank = blank_r;
    assign bus.ndig  = ndig_r;
    assign bus.ovf   = ovf_r;
    assign bus.valid = (state == DONE);
    assign bus.busy  = (state != IDLE);
    assign bus.ovr   = ovr_r;
endmodule

// File: tb/tb_freq_bcd_conv.sv
// Directed self-checking bench for freq_bcd_conv.
// Expected values are computed by hand from the input words.
module tb_freq_bcd_conv;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    freq_bcd_conv_if #(.W(32), .D(10)) bus ();

    freq_bcd_conv #(.W(32), .D(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Raise upd for two cycles, then hold it low for two; c is the cycle count when upd went high
    task automatic applyStimulus(input logic [31:0] f, input logic o, output int c);
        @(negedge clk);
        bus.freq_in = f;
        bus.ovf_in  = o;
        bus.upd     = 1'b1;
        c = cyc;
        repeat (2) @(negedge clk);
        bus.upd = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic waitValid(input int budget, output int c, output logic seen);
        seen = 1'b0;
        c = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) begin
                seen = 1'b1;
                c = cyc;
            end
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_bcd"},   bus.bcd,   40'h0);
        checkOutput({tag, "_blank"}, bus.blank, 10'b1111111110);
        checkOutput({tag, "_ndig"},  bus.ndig,  4'd1);
        checkOutput({tag, "_ovf"},   bus.ovf,   1'b0);
        checkOutput({tag, "_valid"}, bus.valid, 1'b0);
        checkOutput({tag, "_busy"},  bus.busy,  1'b0);
        checkOutput({tag, "_ovr"},   bus.ovr,   1'b0);
    endtask

    initial begin
        int   c1, c2, v1, v2, vcount, bcount;
        logic seen;

        bus.freq_in = '0;
        bus.ovf_in  = 1'b0;
        bus.upd     = 1'b0;
        repeat (3) @(negedge clk);
        checkReset("rst");
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Zero input: single digit, all upper digits blanked
        applyStimulus(32'd0, 1'b0, c1);
        waitValid(60, v1, seen);
        checkOutput("zero_seen", seen, 1'b1);
        checkOutput("zero_lat", v1 - c1, 35);
        checkOutput("zero_bcd", bus.bcd, 40'h0);
        checkOutput("zero_ndig", bus.ndig, 4'd1);
        checkOutput("zero_blank", bus.blank, 10'b1111111110);
        @(negedge clk);
        checkOutput("zero_pulse", bus.valid, 1'b0);
        checkOutput("zero_idle", bus.busy, 1'b0);

        // Full-scale input must not wrap
        applyStimulus(32'd4294967295, 1'b1, c1);
        waitValid(60, v1, seen);
        checkOutput("max_seen", seen, 1'b1);
        checkOutput("max_lat", v1 - c1, 35);
        checkOutput("max_bcd", bus.bcd, 40'h4294967295);
        checkOutput("max_ndig", bus.ndig, 4'd10);
        checkOutput("max_blank", bus.blank, 10'b0);
        checkOutput("max_ovf", bus.ovf, 1'b1);

        applyStimulus(32'd100000000, 1'b0, c1);
        waitValid(60, v1, seen);
        checkOutput("e8_seen", seen, 1'b1);
        checkOutput("e8_bcd", bus.bcd, 40'h0100000000);
        checkOutput("e8_ndig", bus.ndig, 4'd9);
        checkOutput("e8_blank", bus.blank, 10'b1000000000);
        checkOutput("e8_ovf", bus.ovf, 1'b0);
        bus.freq_in = 32'd777;
        repeat (10) @(negedge clk);
        checkOutput("e8_hold_bcd", bus.bcd, 40'h0100000000);
        checkOutput("e8_hold_ndig", bus.ndig, 4'd9);

        // Second request during SHIFT queues behind the first
        applyStimulus(32'd98765, 1'b0, c1);
        repeat (4) @(negedge clk);
        applyStimulus(32'd12345, 1'b0, c2);
        waitValid(60, v1, seen);
        checkOutput("q1_seen", seen, 1'b1);
        checkOutput("q1_lat", v1 - c1, 35);
        checkOutput("q1_bcd", bus.bcd, 40'h0000098765);
        waitValid(60, v2, seen);
        checkOutput("q2_seen", seen, 1'b1);
        checkOutput("q2_gap", v2 - v1, 33);
        checkOutput("q2_bcd", bus.bcd, 40'h0000012345);
        checkOutput("q2_ndig", bus.ndig, 4'd5);
        checkOutput("q2_blank", bus.blank, 10'b1111100000);
        checkOutput("q2_ovr", bus.ovr, 1'b0);
        @(negedge clk);
        checkOutput("q2_idle", bus.busy, 1'b0);

        // Three requests in one conversion: newest wins, overrun flagged
        applyStimulus(32'd111, 1'b0, c1);
        applyStimulus(32'd222, 1'b0, c2);
        applyStimulus(32'd333, 1'b1, c2);
        waitValid(60, v1, seen);
        checkOutput("ov1_seen", seen, 1'b1);
        checkOutput("ov1_bcd", bus.bcd, 40'h0000000111);
        checkOutput("ov1_ovf", bus.ovf, 1'b0);
        waitValid(60, v2, seen);
        checkOutput("ov2_seen", seen, 1'b1);
        checkOutput("ov2_gap", v2 - v1, 33);
        checkOutput("ov2_bcd", bus.bcd, 40'h0000000333);
        checkOutput("ov2_ndig", bus.ndig, 4'd3);
        checkOutput("ov2_blank", bus.blank, 10'b1111111000);
        checkOutput("ov2_ovf", bus.ovf, 1'b1);
        checkOutput("ov2_ovr", bus.ovr, 1'b1);
        @(negedge clk);
        checkOutput("ov2_idle", bus.busy, 1'b0);

        // Reset mid-conversion, upd held high through release
        applyStimulus(32'd55555, 1'b0, c1);
        repeat (6) @(negedge clk);
        checkOutput("abort_busy", bus.busy, 1'b1);
        reset = 1'b0;
        bus.upd = 1'b1;
        vcount = 0;
        bcount = 0;
        repeat (3) @(negedge clk) if (bus.valid === 1'b1) vcount++;
        checkReset("abort");
        reset = 1'b1;
        repeat (50) @(negedge clk) begin
            if (bus.valid === 1'b1) vcount++;
            if (bus.busy === 1'b1) bcount++;
        end
        checkOutput("abort_no_valid", vcount, 0);
        checkOutput("abort_no_busy", bcount, 0);
        bus.upd = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(32'd42, 1'b0, c1);
        waitValid(60, v1, seen);
        checkOutput("rec_seen", seen, 1'b1);
        checkOutput("rec_lat", v1 - c1, 35);
        checkOutput("rec_bcd", bus.bcd, 40'h0000000042);
        checkOutput("rec_ndig", bus.ndig, 4'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/freq_bcd_conv.md
FREQ_BCD_CONV -- requirements
Module: freq_bcd_conv

Interface
REQ-001 Parameter: W, 32, binary input width; this block SHALL be built and verified only for W=32.
REQ-002 Parameter: D, 10, BCD digit count; D*4 SHALL be at least enough to hold 2^W-1 (D=10 for W=32).
REQ-003 clk  input  1  conversion clock; all state SHALL be registered on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-005 freq_in  input  W  measured frequency word from the upstream meter; stable for a full measurement interval.
REQ-006 ovf_in  input  1  upstream counter-overflow indication, sampled together with freq_in.
REQ-007 upd  input  1  upstream update level, asynchronous to clk; each rising edge requests one conversion.
REQ-008 bcd  output  4*D  packed BCD result; digit 0 = bits [3:0], least significant.
REQ-009 blank  output  D  leading-zero mask; bit i=1 means digit i is a leading zero.
REQ-010 ndig  output  4  number of significant digits, range 1..D.
REQ-011 ovf  output  1  ovf_in value captured with the displayed result.
REQ-012 valid  output  1  one-cycle pulse; bcd/blank/ndig/ovf updated this cycle.
REQ-013 busy  output  1  high while a conversion is in progress.
REQ-014 ovr  output  1  sticky flag: an update request was lost.

Function
REQ-015 upd SHALL pass a 2-flop synchronizer, then a third register; request = sync2 & ~sync3.
REQ-016 Each detected request SHALL copy freq_in and ovf_in into a hold register, whether or not busy.
REQ-017 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-018 IDLE with a request: load the shift register from hold, clear the scratch BCD, set the bit counter to 0, go to SHIFT.
REQ-019 SHIFT: each cycle, add 3 to every scratch digit >=5, then shift {scratch, binary} left one bit; increment the counter.
REQ-020 After exactly W shift cycles, the FSM SHALL go to DONE and load bcd, blank, ndig and ovf from scratch and hold.
REQ-021 valid SHALL be high only in the DONE cycle; busy SHALL be high in SHIFT and DONE.
REQ-022 Latency: with upd first sampled high at edge k, valid SHALL be high for exactly the cycle after edge k+34.
REQ-023 ndig SHALL be the index of the most significant nonzero digit plus 1; for value 0, ndig=1.
REQ-024 blank SHALL set bits ndig..D-1; bit 0 SHALL never be set.
REQ-025 A request while busy SHALL set a one-deep pending flag.
REQ-026 From DONE with pending set, the FSM SHALL clear pending and start the next conversion directly (DONE->SHIFT, load as in REQ-018); otherwise DONE->IDLE.
REQ-027 A request while pending is already set SHALL overwrite hold (newest value wins) and set ovr.
REQ-028 A request in the DONE cycle SHALL count as pending.
REQ-029 bcd, blank, ndig and ovf SHALL hold their values between valid pulses.
REQ-030 Digit correction SHALL never produce a digit >9 at the output; the input value 2^32-1 SHALL NOT wrap.

Reset
REQ-031 While reset is low: state=IDLE; all synchronizer, pending, counter and hold bits = 0; bcd=0, blank={D-1{1},0}, ndig=1, ovf=0, valid=0, busy=0, ovr=0.
REQ-032 Reset asserted mid-conversion SHALL abort it with no valid pulse; any pending request SHALL be lost.
REQ-033 After reset release, a request SHALL need a fresh upd rising edge; upd already high at release SHALL NOT trigger a conversion.

Verification
REQ-034 freq_in=0, upd pulse -> valid once; bcd=0, ndig=1, blank=10'b1111111110.
REQ-035 freq_in=4294967295, ovf_in=1 -> bcd=40'h4294967295, ndig=10, blank=0, ovf=1; valid is in the cycle after edge k+34.
REQ-036 freq_in=100000000 -> bcd=40'h0100000000, ndig=9, blank=10'b1000000000.
REQ-037 Second upd edge during SHIFT with freq_in=12345 -> the first result is unaffected; second valid exactly 33 cycles after the first; bcd=40'h0000012345, ndig=5; ovr=0.
REQ-038 Three upd edges within one conversion -> ovr=1; the second result equals the last-requested freq_in.
REQ-039 reset low in mid-SHIFT -> no valid; all outputs at reset values; upd held high through release -> no conversion.
